// File: rtl/prom_seq_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : prom_seq_arb_if
// Purpose  : Request/ack and ROM-side signal bundle for prom_seq_arb.
// Revision : 1.0  initial release
// ============================================================================
interface prom_seq_arb_if #(
    parameter int HEIGHT = 10
) ();
    logic              req0;
    logic [HEIGHT-1:0] addr0;
    logic              req1;
    logic [HEIGHT-1:0] addr1;
    logic              ack0;
    logic              ack1;
    logic [15:0]       dout;
    logic              busy;
    logic [HEIGHT-1:0] rom_a;
    logic              rom_cs1_;
    logic              rom_cs2_;
    logic [3:0]        rom_q;

    // slave: the arbiter; master: requesters plus the ROM device
    modport slave (
        input  req0, addr0, req1, addr1, rom_q,
        output ack0, ack1, dout, busy, rom_a, rom_cs1_, rom_cs2_
    );

    modport master (
        output req0, addr0, req1, addr1, rom_q,
        input  ack0, ack1, dout, busy, rom_a, rom_cs1_, rom_cs2_
    );
endinterface
`default_nettype wire

// File: rtl/prom_seq_arb.sv
`default_nettype none
// ============================================================================
// Module   : prom_seq_arb
// Purpose  : Two-requester round-robin arbiter reading 16-bit words from a
//            4-bit-wide PROM as four sequential nibble accesses.
// Revision : 1.0  initial release
// ============================================================================
module prom_seq_arb #(
    parameter int WAIT   = 2,
    parameter int HEIGHT = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    prom_seq_arb_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0]        c_wait_last = 4'(WAIT - 1);
    localparam logic [HEIGHT-1:0] c_addr_one  = HEIGHT'(1);

    state_t            state_q, state_d;
    logic              gnt_q,   gnt_d;
    logic [1:0]        k_q,     k_d;
    logic [3:0]        w_q,     w_d;
    logic [15:0]       dout_q,  dout_d;
    logic [HEIGHT-1:0] rom_a_q, rom_a_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b1;
            k_q     <= 2'd0;
            w_q     <= 4'd0;
            dout_q  <= 16'd0;
            rom_a_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            k_q     <= k_d;
            w_q     <= w_d;
            dout_q  <= dout_d;
            rom_a_q <= rom_a_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        k_d     = k_q;
        w_d     = w_q;
        dout_d  = dout_q;
        rom_a_d = rom_a_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // gnt_q doubles as the "last granted" round-robin pointer
                    gnt_d   = (bus.req0 && bus.req1) ? ~gnt_q : bus.req1;
                    rom_a_d = gnt_d ? bus.addr1 : bus.addr0;
                    k_d     = 2'd0;
                    w_d     = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (w_q == c_wait_last) begin
                    dout_d[{k_q, 2'b00} +: 4] = bus.rom_q;
                    w_d = 4'd0;
                    k_d = k_q + 2'd1;
                    // rom_a stays on the last nibble so it holds once idle
                    if (k_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        rom_a_d = rom_a_q + c_addr_one;
                    end
                end else begin
                    w_d = w_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ack0     = (state_q == DONE) && !gnt_q;
    assign bus.ack1     = (state_q == DONE) &&  gnt_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.rom_cs1_ = (state_q != ACCESS);
    assign bus.rom_cs2_ = (state_q != ACCESS);
    assign bus.dout     = dout_q;
    assign bus.rom_a    = rom_a_q;

endmodule
`default_nettype wire

// File: tb/tb_prom_seq_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_prom_seq_arb
// Purpose  : Directed self-checking bench for prom_seq_arb (WAIT=2 and WAIT=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_prom_seq_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [3:0] rom [0:1023];

    prom_seq_arb_if #(.HEIGHT(10)) ifa ();
    prom_seq_arb_if #(.HEIGHT(10)) ifb ();

    assign ifa.rom_q = rom[ifa.rom_a];
    assign ifb.rom_q = rom[ifb.rom_a];

    prom_seq_arb #(.WAIT(2), .HEIGHT(10)) u_dut_w2 (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    prom_seq_arb #(.WAIT(1), .HEIGHT(10)) u_dut_w1 (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until an ack on the WAIT=2 instance, bounded.
    task automatic wait_ack(output logic who, output logic [15:0] d);
        logic got;
        got = 1'b0;
        who = 1'b0;
        d   = 16'd0;
        for (int n = 0; n < 60 && !got; n++) begin
            tick();
            if (ifa.ack0 && ifa.ack1) chk("dual_ack", 32'd1, 32'd0);
            if (ifa.ack0 || ifa.ack1) begin
                got = 1'b1;
                who = ifa.ack1;
                d   = ifa.dout;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic        who;
        logic [15:0] d;
        int          lat;
        int          cs_cnt;
        logic        got;

        for (int i = 0; i < 1024; i++) rom[i] = 4'h0;
        rom[10'h010] = 4'h1; rom[10'h011] = 4'h2; rom[10'h012] = 4'h3; rom[10'h013] = 4'h4;
        rom[10'h020] = 4'h5; rom[10'h021] = 4'h6; rom[10'h022] = 4'h7; rom[10'h023] = 4'h8;
        rom[10'h3FE] = 4'hA; rom[10'h3FF] = 4'hB; rom[10'h000] = 4'hC; rom[10'h001] = 4'hD;

        ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.addr0 = '0; ifa.addr1 = '0;
        ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.addr0 = '0; ifb.addr1 = '0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",  {31'd0, ifa.busy},     32'd0);
        chk("rst_ack",   {30'd0, ifa.ack1, ifa.ack0}, 32'd0);
        chk("rst_dout",  {16'd0, ifa.dout},     32'd0);
        chk("rst_rom_a", {22'd0, ifa.rom_a},    32'd0);
        chk("rst_cs",    {30'd0, ifa.rom_cs1_, ifa.rom_cs2_}, 32'd3);

        // Single read of 0x010..0x013, WAIT=2
        ifa.req0 = 1'b1; ifa.addr0 = 10'h010;
        tick();
        chk("t1_busy_grant", {31'd0, ifa.busy}, 32'd1);
        chk("t1_cs_grant",   {30'd0, ifa.rom_cs1_, ifa.rom_cs2_}, 32'd0);
        chk("t1_rom_a0",     {22'd0, ifa.rom_a}, 32'h010);
        for (int j = 1; j < 8; j++) begin
            tick();
            chk("t1_rom_a_step", {22'd0, ifa.rom_a}, 32'h010 + 32'(j / 2));
            chk("t1_no_early_ack", {31'd0, ifa.ack0}, 32'd0);
        end
        tick();
        chk("t1_ack0_lat8", {31'd0, ifa.ack0}, 32'd1);
        chk("t1_ack1_low",  {31'd0, ifa.ack1}, 32'd0);
        chk("t1_dout",      {16'd0, ifa.dout}, 32'h4321);
        chk("t1_cs_done",   {30'd0, ifa.rom_cs1_, ifa.rom_cs2_}, 32'd3);
        ifa.req0 = 1'b0;
        tick();
        chk("t1_idle_busy", {31'd0, ifa.busy}, 32'd0);
        chk("t1_ack_gone",  {31'd0, ifa.ack0}, 32'd0);
        chk("t1_rom_a_hold", {22'd0, ifa.rom_a}, 32'h013);

        // Round-robin with both requests held, pointer fresh from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.req0 = 1'b1; ifa.addr0 = 10'h010;
        ifa.req1 = 1'b1; ifa.addr1 = 10'h020;
        for (int t = 0; t < 4; t++) begin
            wait_ack(who, d);
            chk("rr_order", {31'd0, who}, 32'(t % 2));
            chk("rr_dout",  {16'd0, d}, (t % 2 == 0) ? 32'h4321 : 32'h8765);
        end
        ifa.req0 = 1'b0; ifa.req1 = 1'b0;
        tick();

        // Address wrap 0x3FE -> 0x001 on requester 1, req dropped after grant
        ifa.req1 = 1'b1; ifa.addr1 = 10'h3FE;
        tick();
        chk("wrap_rom_a0", {22'd0, ifa.rom_a}, 32'h3FE);
        ifa.req1 = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        chk("wrap_rom_a_000", {22'd0, ifa.rom_a}, 32'h000);
        wait_ack(who, d);
        chk("wrap_who",  {31'd0, who}, 32'd1);
        chk("wrap_dout", {16'd0, d},   32'hDCBA);
        tick();

        // Reset during third nibble
        ifa.req0 = 1'b1; ifa.addr0 = 10'h010;
        tick();
        for (int j = 0; j < 5; j++) tick();
        chk("rst_mid_partial", {16'd0, ifa.dout}, 32'hDC21);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, ifa.busy}, 32'd0);
        chk("rst_mid_cs",   {30'd0, ifa.rom_cs1_, ifa.rom_cs2_}, 32'd3);
        chk("rst_mid_dout", {16'd0, ifa.dout}, 32'd0);
        chk("rst_mid_ack",  {30'd0, ifa.ack1, ifa.ack0}, 32'd0);
        wait_ack(who, d);
        chk("after_rst_who",  {31'd0, who}, 32'd0);
        chk("after_rst_dout", {16'd0, d},   32'h4321);
        ifa.req0 = 1'b0;
        tick(); tick();

        // WAIT=1 instance: 4-cycle latency, addr change ignored
        ifb.req0 = 1'b1; ifb.addr0 = 10'h020;
        tick();
        ifb.addr0 = 10'h010;
        lat = 0; cs_cnt = 0; got = 1'b0;
        while (lat < 20 && !got) begin
            if (ifb.ack0) begin
                got = 1'b1;
            end else begin
                if (!ifb.rom_cs1_ && !ifb.rom_cs2_) cs_cnt++;
                tick();
                lat++;
            end
        end
        chk("w1_ack_seen", {31'd0, got}, 32'd1);
        chk("w1_latency",  32'(lat),    32'd4);
        chk("w1_cs_cycles", 32'(cs_cnt), 32'd4);
        chk("w1_dout",     {16'd0, ifb.dout}, 32'h8765);
        ifb.req0 = 1'b0;
        tick();
        chk("w1_idle", {31'd0, ifb.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prom_seq_arb.md
PROM_SEQ_ARB -- requirements
Module: prom_seq_arb

Interface
REQ-001 Parameter WAIT, default 2, ROM access cycles per nibble; legal range 1..15.
REQ-002 Parameter HEIGHT, default 10, ROM address width (1024 x 4 device).
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  requester 0 read request, level, held until ack0.
REQ-006 addr0  input  HEIGHT  requester 0 base nibble address.
REQ-007 req1  input  1  requester 1 read request, level, held until ack1.
REQ-008 addr1  input  HEIGHT  requester 1 base nibble address.
REQ-009 ack0  output  1  one-cycle pulse: dout valid for requester 0.
REQ-010 ack1  output  1  one-cycle pulse: dout valid for requester 1.
REQ-011 dout  output  16  assembled word, nibble 0 in bits 3:0.
REQ-012 busy  output  1  high while a transaction is in progress.
REQ-013 rom_a  output  HEIGHT  ROM address.
REQ-014 rom_cs1_  output  1  ROM chip select 1, active-low.
REQ-015 rom_cs2_  output  1  ROM chip select 2, active-low.
REQ-016 rom_q  input  4  ROM data.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE; the FSM has no other states.
REQ-018 IDLE: at a rising edge with any req high, grant one requester, latch its addr as base, set nibble index k=0 and wait counter w=0, and go to ACCESS.
REQ-019 Arbitration: round-robin; with both requests high, grant the requester not granted last; with one request high, grant it.
REQ-020 Address is sampled only at the grant edge; addr changes afterwards are ignored.
REQ-021 ACCESS: rom_a = (base + k) mod 2^HEIGHT (wrap 1023 -> 0); rom_cs1_ = rom_cs2_ = 0.
REQ-022 ACCESS: w increments each cycle; at the edge where w == WAIT-1, capture rom_q into dout[4k+3:4k], clear w, and increment k.
REQ-023 ACCESS -> DONE on the edge that captures nibble k=3.
REQ-024 DONE lasts exactly one cycle: the granted requester's ack is high, dout is stable, and the FSM then returns to IDLE.
REQ-025 Latency: ack is high in the cycle beginning 4*WAIT edges after the grant edge (8 cycles for WAIT=2).
REQ-026 Outside ACCESS, rom_cs1_ = rom_cs2_ = 1 and rom_a holds its last value.
REQ-027 dout holds its value until the next capture; nibbles are overwritten progressively during the next transaction.
REQ-028 busy = 1 in ACCESS and DONE, and 0 in IDLE.
REQ-029 ack0 and ack1 are never high simultaneously, and at most one is high per transaction.
REQ-030 A requester deasserts req in the cycle after its ack; a req still high at the next IDLE edge starts a new transaction, subject to round-robin.
REQ-031 A req dropped before grant starts nothing; a req dropped after grant does not abort the transaction, and ack is still issued.
REQ-032 A request arriving during ACCESS or DONE waits; it is evaluated at the next IDLE edge.

Reset
REQ-033 rst high at a rising edge forces IDLE, k=0, w=0, ack0=ack1=0, busy=0, dout=0, rom_a=0, and rom_cs1_=rom_cs2_=1.
REQ-034 Reset sets the round-robin pointer to "last granted = 1", so req0 wins the first tie.
REQ-035 Reset mid-transaction aborts without an ack; rst overrides all other inputs in the same cycle.

Verification
REQ-036 ROM word 0x010..0x013 = 1,2,3,4; req0 with addr0=0x010, WAIT=2 -> rom_a steps 0x010..0x013, two cycles each; ack0 pulses 8 cycles after grant; dout=0x4321.
REQ-037 req0 and req1 raised in the same cycle after reset -> requester 0 served first, then requester 1; held requests alternate 0,1,0,1.
REQ-038 addr1=0x3FE, ROM[0x3FE]=0xA, ROM[0x3FF]=0xB, ROM[0]=0xC, ROM[1]=0xD -> rom_a wraps to 0x000; dout=0xDCBA.
REQ-039 rst asserted during the third nibble -> next cycle IDLE, chip selects high, dout=0, no ack; a following req0 completes normally.
REQ-040 WAIT=1 build -> ack 4 cycles after grant; chip selects low for exactly 4 consecutive cycles; addr0 changed mid-transaction has no effect.
